execute_cycle: RTL and testbench
================================

EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have inputs RegWriteE 1, ResultSrcE 2, MemWriteE 1, JumpE 1, BranchE 1, ALUSrcE 1, ALUControlE 4, Funct3E 3: decode controls for the instruction in EX.
REQ-004 SHALL have inputs RD1E, RD2E, ImmExtE, PCE, PCPlus4E  32 each, and RdE  5: operands and destination from the ID/EX register.
REQ-005 SHALL have inputs ForwardAE, ForwardBE  2 each, ResultW  32, ALUResultM_fb  32: forwarding selects and sources.
REQ-006 SHALL have outputs PCSrcE  1, PCTargetE  32: branch/jump redirect.
REQ-007 SHALL have output StallE  1: high while the multiplier holds EX.
REQ-008 SHALL have registered outputs RegWriteM 1, ResultSrcM 2, MemWriteM 1, ALUResultM 32, WriteDataM 32, RdM 5, PCPlus4M 32: the EX/MEM register.

Function
REQ-009 SHALL form SrcAE and WriteDataE by forward select: 00 register (RD1E/RD2E), 01 ResultW, 10 ALUResultM_fb, 11 treated as 00.
REQ-010 SHALL set SrcBE = ImmExtE when ALUSrcE=1, else WriteDataE.
REQ-011 SHALL compute ALU ops by ALUControlE: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 MUL; any other code yields 0.
REQ-012 SHALL use SrcBE[4:0] only as shift amount; all arithmetic wraps modulo 2^32.
REQ-013 SHALL produce MUL result as the low 32 bits of the unsigned 64-bit product (identical to signed low word).
REQ-014 SHALL compute PCTargetE = PCE + ImmExtE, modulo 2^32, combinationally.
REQ-015 SHALL evaluate branch condition on SrcAE vs WriteDataE by Funct3E: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 never taken.
REQ-016 SHALL drive PCSrcE = JumpE | (BranchE & condition), combinationally, forced 0 while StallE=1.
REQ-017 SHALL implement multiplier FSM states IDLE, BUSY, DONE.
REQ-018 IDLE: if ALUControlE=1010, latch SrcAE and SrcBE, clear 5-bit counter, go BUSY, StallE=1 this cycle; otherwise stay IDLE, StallE=0.
REQ-019 BUSY: one shift-add step per cycle on latched operands, counter increments; after step with counter=31 go DONE; StallE=1.
REQ-020 DONE: StallE=0, product drives ALUResultM input; next state IDLE.
REQ-021 Single-cycle ops: ALUResultM/controls registered one cycle after entering EX (latency 1).
REQ-022 MUL latency: 34 cycles in EX (1 IDLE + 32 BUSY + 1 DONE); product visible on ALUResultM the cycle after DONE.
REQ-023 While StallE=1, EX/MEM register SHALL load a bubble: RegWriteM=0, MemWriteM=0, ResultSrcM=00, RdM=0, data fields 0.
REQ-024 Upstream holds ID/EX stable while StallE=1; block SHALL ignore changes on forwarding inputs during BUSY (latched operands used).
REQ-025 Back-to-back MUL: second MUL SHALL enter IDLE->BUSY on the cycle after DONE with no extra gap.
REQ-026 WriteDataM SHALL capture forwarded WriteDataE, not RD2E.

Reset
REQ-027 When reset=1 at posedge: FSM to IDLE, counter and operand latches 0, all EX/MEM outputs 0; StallE and PCSrcE 0 the following cycle; reset overrides any in-flight MUL, which is discarded.

Verification
REQ-028 ADD RD1E=5, ImmExtE=7, ALUSrcE=1, RdE=3, RegWriteE=1 -> next cycle ALUResultM=12, RdM=3, RegWriteM=1.
REQ-029 ForwardAE=10, ALUResultM_fb=0x100, RD1E=0, SUB with RD2E=1 -> ALUResultM=0xFF; ForwardAE=01 with ResultW=9 -> 8.
REQ-030 BLT Funct3E=100, SrcA=0xFFFFFFFF, SrcB=1, BranchE=1, PCE=0x40, ImmExtE=-8 -> PCSrcE=1, PCTargetE=0x38; BLTU same operands -> PCSrcE=0.
REQ-031 MUL 0xFFFFFFFF x 3 -> StallE high 33 cycles, 33 bubbles in M, then ALUResultM=0xFFFFFFFD with RegWriteM=1.
REQ-032 reset asserted at BUSY counter=10 -> next cycle StallE=0, all M outputs 0; fresh ADD 1+1 afterwards yields ALUResultM=2.
REQ-033 SRA 0x80000000 by 31 -> 0xFFFFFFFF; SRL same -> 0x00000001; ALUControlE=1111 -> ALUResultM=0.

Source files
------------

// File: rtl/execute_cycle_if.sv
`default_nettype none
// ============================================================================
//  Module      : execute_cycle_if
//  Description : ID/EX operands and controls in, EX/MEM register and
//                redirect/stall status out, for the execute stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface execute_cycle_if;
    // Decode controls for the instruction in EX
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic        ALUSrcE;
    logic [3:0]  ALUControlE;
    logic [2:0]  Funct3E;
    // Operands and destination
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [4:0]  RdE;
    // Forwarding selects and sources
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic [31:0] ResultW;
    logic [31:0] ALUResultM_fb;
    // Redirect and stall
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallE;
    // EX/MEM register
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;

    modport master (
        output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
               ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE,
               ForwardAE, ForwardBE, ResultW, ALUResultM_fb,
        input  PCSrcE, PCTargetE, StallE, RegWriteM, ResultSrcM, MemWriteM,
               ALUResultM, WriteDataM, RdM, PCPlus4M
    );

    modport slave (
        input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
               ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE,
               ForwardAE, ForwardBE, ResultW, ALUResultM_fb,
        output PCSrcE, PCTargetE, StallE, RegWriteM, ResultSrcM, MemWriteM,
               ALUResultM, WriteDataM, RdM, PCPlus4M
    );
endinterface
`default_nettype wire

// File: rtl/execute_cycle.sv
`default_nettype none
// ============================================================================
//  Module      : execute_cycle
//  Description : Pipeline execute stage: forwarding, ALU, branch resolution,
//                32-step shift-add multiplier and the EX/MEM register.
//  Revision    : 1.0  initial release
// ============================================================================
module execute_cycle (
    input  wire              clk,
    input  wire              reset,
    execute_cycle_if.slave   ex
);

    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b0001;
    localparam logic [3:0] c_ALU_AND  = 4'b0010;
    localparam logic [3:0] c_ALU_OR   = 4'b0011;
    localparam logic [3:0] c_ALU_XOR  = 4'b0100;
    localparam logic [3:0] c_ALU_SLT  = 4'b0101;
    localparam logic [3:0] c_ALU_SLTU = 4'b0110;
    localparam logic [3:0] c_ALU_SLL  = 4'b0111;
    localparam logic [3:0] c_ALU_SRL  = 4'b1000;
    localparam logic [3:0] c_ALU_SRA  = 4'b1001;
    localparam logic [3:0] c_ALU_MUL  = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mulState_t;

    mulState_t   r_state;
    mulState_t   w_nextState;
    logic        w_stall;
    logic        w_mulStart;

    logic [31:0] r_mulA;
    logic [31:0] r_mulB;
    logic [31:0] r_acc;
    logic [4:0]  r_count;
    logic [31:0] w_partial;

    logic [31:0] w_srcA;
    logic [31:0] w_writeData;
    logic [31:0] w_srcB;
    logic [4:0]  w_shamt;
    logic [31:0] w_aluResult;
    logic [31:0] w_exResult;

    logic        w_eq;
    logic        w_lt;
    logic        w_ltu;
    logic        w_cond;

    // ------------------------------------------------------------------
    // Operand forwarding; select 11 falls back to the register value
    // ------------------------------------------------------------------
    always_comb begin
        case (ex.ForwardAE)
            2'b01:   w_srcA = ex.ResultW;
            2'b10:   w_srcA = ex.ALUResultM_fb;
            default: w_srcA = ex.RD1E;
        endcase
        case (ex.ForwardBE)
            2'b01:   w_writeData = ex.ResultW;
            2'b10:   w_writeData = ex.ALUResultM_fb;
            default: w_writeData = ex.RD2E;
        endcase
    end

    assign w_srcB  = ex.ALUSrcE ? ex.ImmExtE : w_writeData;
    assign w_shamt = w_srcB[4:0];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    always_comb begin
        w_aluResult = 32'd0;
        case (ex.ALUControlE)
            c_ALU_ADD:  w_aluResult = w_srcA + w_srcB;
            c_ALU_SUB:  w_aluResult = w_srcA - w_srcB;
            c_ALU_AND:  w_aluResult = w_srcA & w_srcB;
            c_ALU_OR:   w_aluResult = w_srcA | w_srcB;
            c_ALU_XOR:  w_aluResult = w_srcA ^ w_srcB;
            c_ALU_SLT:  w_aluResult = {31'd0, $signed(w_srcA) < $signed(w_srcB)};
            c_ALU_SLTU: w_aluResult = {31'd0, w_srcA < w_srcB};
            c_ALU_SLL:  w_aluResult = w_srcA << w_shamt;
            c_ALU_SRL:  w_aluResult = w_srcA >> w_shamt;
            c_ALU_SRA:  w_aluResult = $signed(w_srcA) >>> w_shamt;
            c_ALU_MUL:  w_aluResult = r_acc;
            default:    w_aluResult = 32'd0;
        endcase
    end

    // The product only becomes valid in DONE; select it explicitly there
    assign w_exResult = (r_state == S_DONE) ? r_acc : w_aluResult;

    // ------------------------------------------------------------------
    // Branch resolution, compared on forwarded register operands
    // ------------------------------------------------------------------
    assign w_eq  = (w_srcA == w_writeData);
    assign w_lt  = ($signed(w_srcA) < $signed(w_writeData));
    assign w_ltu = (w_srcA < w_writeData);

    always_comb begin
        w_cond = 1'b0;
        case (ex.Funct3E)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = ~w_eq;
            3'b100:  w_cond = w_lt;
            3'b101:  w_cond = ~w_lt;
            3'b110:  w_cond = w_ltu;
            3'b111:  w_cond = ~w_ltu;
            default: w_cond = 1'b0;
        endcase
    end

    assign ex.PCTargetE = ex.PCE + ex.ImmExtE;
    assign ex.PCSrcE    = ~w_stall & (ex.JumpE | (ex.BranchE & w_cond));
    assign ex.StallE    = w_stall;

    // ------------------------------------------------------------------
    // Multiplier control
    // ------------------------------------------------------------------
    assign w_mulStart = (ex.ALUControlE == c_ALU_MUL);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mulStart) begin
                    w_nextState = S_BUSY;
                    w_stall     = 1'b1;
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (r_count == 5'd31) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // One partial product per BUSY cycle, operands frozen at start
    assign w_partial = r_mulB[r_count] ? (r_mulA << r_count) : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mulA  <= 32'd0;
            r_mulB  <= 32'd0;
            r_acc   <= 32'd0;
            r_count <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mulStart) begin
                        r_mulA  <= w_srcA;
                        r_mulB  <= w_srcB;
                        r_acc   <= 32'd0;
                        r_count <= 5'd0;
                    end
                end
                S_BUSY: begin
                    r_acc   <= r_acc + w_partial;
                    r_count <= r_count + 5'd1;
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM register; a stalled EX pushes a bubble downstream
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || w_stall) begin
            ex.RegWriteM  <= 1'b0;
            ex.ResultSrcM <= 2'b00;
            ex.MemWriteM  <= 1'b0;
            ex.ALUResultM <= 32'd0;
            ex.WriteDataM <= 32'd0;
            ex.RdM        <= 5'd0;
            ex.PCPlus4M   <= 32'd0;
        end else begin
            ex.RegWriteM  <= ex.RegWriteE;
            ex.ResultSrcM <= ex.ResultSrcE;
            ex.MemWriteM  <= ex.MemWriteE;
            ex.ALUResultM <= w_exResult;
            ex.WriteDataM <= w_writeData;
            ex.RdM        <= ex.RdE;
            ex.PCPlus4M   <= ex.PCPlus4E;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_cycle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_cycle
//  Description : Directed self-checking bench for execute_cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_execute_cycle;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   nStall;
    int   nBubble;

    execute_cycle_if bus ();

    execute_cycle dut (
        .clk   (clk),
        .reset (reset),
        .ex    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs;
        bus.RegWriteE     = 1'b0;
        bus.ResultSrcE    = 2'b00;
        bus.MemWriteE     = 1'b0;
        bus.JumpE         = 1'b0;
        bus.BranchE       = 1'b0;
        bus.ALUSrcE       = 1'b0;
        bus.ALUControlE   = 4'b0000;
        bus.Funct3E       = 3'b000;
        bus.RD1E          = 32'd0;
        bus.RD2E          = 32'd0;
        bus.ImmExtE       = 32'd0;
        bus.PCE           = 32'd0;
        bus.PCPlus4E      = 32'd0;
        bus.RdE           = 5'd0;
        bus.ForwardAE     = 2'b00;
        bus.ForwardBE     = 2'b00;
        bus.ResultW       = 32'd0;
        bus.ALUResultM_fb = 32'd0;
    endtask

    // Runs EX until the stall drops, counting stalled cycles and bubbles in M
    task automatic waitMul(input bit glitchFwd);
        nStall  = 0;
        nBubble = 0;
        while (bus.StallE && nStall < 60) begin
            step();
            nStall++;
            if (!bus.RegWriteM && bus.RdM == 5'd0 && bus.ALUResultM == 32'd0 &&
                bus.PCPlus4M == 32'd0)
                nBubble++;
            if (glitchFwd && nStall == 5) begin
                bus.ForwardAE = 2'b01;
                bus.ResultW   = 32'h0000_DEAD;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clearInputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checkVal("rst_ALUResultM", bus.ALUResultM, 32'd0);
        checkVal("rst_RegWriteM", {31'd0, bus.RegWriteM}, 32'd0);
        checkVal("rst_StallE", {31'd0, bus.StallE}, 32'd0);
        checkVal("rst_PCSrcE", {31'd0, bus.PCSrcE}, 32'd0);

        // ADD 5 + imm 7
        bus.RD1E = 32'd5; bus.ImmExtE = 32'd7; bus.ALUSrcE = 1'b1;
        bus.RdE = 5'd3; bus.RegWriteE = 1'b1; bus.PCPlus4E = 32'h44;
        step();
        checkVal("add_ALUResultM", bus.ALUResultM, 32'd12);
        checkVal("add_RdM", {27'd0, bus.RdM}, 32'd3);
        checkVal("add_RegWriteM", {31'd0, bus.RegWriteM}, 32'd1);
        checkVal("add_PCPlus4M", bus.PCPlus4M, 32'h44);

        // SUB with forwarded SrcA
        bus.ALUSrcE = 1'b0; bus.ALUControlE = 4'b0001; bus.RD1E = 32'd0;
        bus.RD2E = 32'd1; bus.ForwardAE = 2'b10; bus.ALUResultM_fb = 32'h100;
        step();
        checkVal("sub_fwdM", bus.ALUResultM, 32'hFF);
        checkVal("sub_WriteDataM", bus.WriteDataM, 32'd1);
        bus.ForwardAE = 2'b01; bus.ResultW = 32'd9;
        step();
        checkVal("sub_fwdW", bus.ALUResultM, 32'd8);
        bus.ForwardAE = 2'b11; bus.RD1E = 32'd20;
        step();
        checkVal("sub_fwd11", bus.ALUResultM, 32'd19);
        bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b10; bus.ALUResultM_fb = 32'd5;
        step();
        checkVal("sub_fwdB", bus.ALUResultM, 32'd15);
        checkVal("fwdB_WriteDataM", bus.WriteDataM, 32'd5);

        // Branches
        clearInputs();
        bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 32'd1; bus.BranchE = 1'b1;
        bus.PCE = 32'h40; bus.ImmExtE = 32'hFFFF_FFF8; bus.Funct3E = 3'b100;
        #1;
        checkVal("blt_PCSrcE", {31'd0, bus.PCSrcE}, 32'd1);
        checkVal("blt_PCTargetE", bus.PCTargetE, 32'h38);
        bus.Funct3E = 3'b110; #1;
        checkVal("bltu_PCSrcE", {31'd0, bus.PCSrcE}, 32'd0);
        bus.Funct3E = 3'b101; #1;
        checkVal("bge_PCSrcE", {31'd0, bus.PCSrcE}, 32'd0);
        bus.Funct3E = 3'b111; #1;
        checkVal("bgeu_PCSrcE", {31'd0, bus.PCSrcE}, 32'd1);
        bus.Funct3E = 3'b010; #1;
        checkVal("b010_PCSrcE", {31'd0, bus.PCSrcE}, 32'd0);
        bus.BranchE = 1'b0; bus.JumpE = 1'b1; #1;
        checkVal("jal_PCSrcE", {31'd0, bus.PCSrcE}, 32'd1);

        // MUL 0xFFFFFFFF x 3; jump asserted to confirm redirect is masked
        clearInputs();
        bus.RD1E = 32'hFFFF_FFFF; bus.ImmExtE = 32'd3; bus.ALUSrcE = 1'b1;
        bus.ALUControlE = 4'b1010; bus.RegWriteE = 1'b1; bus.RdE = 5'd7;
        bus.PCPlus4E = 32'h80; bus.JumpE = 1'b1;
        #1;
        checkVal("mul_StallE_start", {31'd0, bus.StallE}, 32'd1);
        checkVal("mul_PCSrcE_masked", {31'd0, bus.PCSrcE}, 32'd0);
        bus.JumpE = 1'b0;
        waitMul(1'b1);
        checkVal("mul_stall_cycles", nStall, 32'd33);
        checkVal("mul_bubbles", nBubble, 32'd33);
        step();
        checkVal("mul_ALUResultM", bus.ALUResultM, 32'hFFFF_FFFD);
        checkVal("mul_RegWriteM", {31'd0, bus.RegWriteM}, 32'd1);
        checkVal("mul_RdM", {27'd0, bus.RdM}, 32'd7);

        // Back-to-back MUL 6 x 7 starts right after DONE
        bus.ForwardAE = 2'b00; bus.RD1E = 32'd6; bus.ImmExtE = 32'd7; bus.RdE = 5'd9;
        #1;
        checkVal("mul2_StallE_start", {31'd0, bus.StallE}, 32'd1);
        waitMul(1'b0);
        checkVal("mul2_stall_cycles", nStall, 32'd33);
        step();
        checkVal("mul2_ALUResultM", bus.ALUResultM, 32'd42);
        checkVal("mul2_RdM", {27'd0, bus.RdM}, 32'd9);

        // Third MUL aborted by reset at counter = 10
        bus.RD1E = 32'd5; bus.ImmExtE = 32'd5; bus.RdE = 5'd4;
        step();
        for (int i = 0; i < 10; i++) step();
        checkVal("abort_StallE_busy", {31'd0, bus.StallE}, 32'd1);
        reset = 1'b1;
        bus.ALUControlE = 4'b0000; bus.RD1E = 32'd1; bus.ImmExtE = 32'd1; bus.RdE = 5'd2;
        step();
        reset = 1'b0;
        #1;
        checkVal("abort_StallE", {31'd0, bus.StallE}, 32'd0);
        checkVal("abort_RegWriteM", {31'd0, bus.RegWriteM}, 32'd0);
        checkVal("abort_RdM", {27'd0, bus.RdM}, 32'd0);
        checkVal("abort_ALUResultM", bus.ALUResultM, 32'd0);
        checkVal("abort_PCPlus4M", bus.PCPlus4M, 32'd0);
        step();
        checkVal("post_reset_add", bus.ALUResultM, 32'd2);
        checkVal("post_reset_RegWriteM", {31'd0, bus.RegWriteM}, 32'd1);

        // Shifts, compares, logic and the illegal code
        clearInputs();
        bus.ALUSrcE = 1'b1; bus.RD1E = 32'h8000_0000; bus.ImmExtE = 32'd31;
        bus.ALUControlE = 4'b1001;
        step();
        checkVal("sra31", bus.ALUResultM, 32'hFFFF_FFFF);
        bus.ALUControlE = 4'b1000;
        step();
        checkVal("srl31", bus.ALUResultM, 32'h0000_0001);
        bus.ALUControlE = 4'b1111;
        step();
        checkVal("illegal_op", bus.ALUResultM, 32'd0);
        bus.RD1E = 32'd1; bus.ImmExtE = 32'h21; bus.ALUControlE = 4'b0111;
        step();
        checkVal("sll_shamt5", bus.ALUResultM, 32'd2);
        bus.RD1E = 32'hFFFF_FFFF; bus.ImmExtE = 32'd1; bus.ALUControlE = 4'b0101;
        step();
        checkVal("slt", bus.ALUResultM, 32'd1);
        bus.ALUControlE = 4'b0110;
        step();
        checkVal("sltu", bus.ALUResultM, 32'd0);
        bus.RD1E = 32'h0000_F0F0; bus.ImmExtE = 32'h0000_0FF0; bus.ALUControlE = 4'b0100;
        step();
        checkVal("xor", bus.ALUResultM, 32'h0000_FF00);
        bus.ALUControlE = 4'b0010;
        step();
        checkVal("and", bus.ALUResultM, 32'h0000_00F0);
        bus.ALUControlE = 4'b0011;
        step();
        checkVal("or", bus.ALUResultM, 32'h0000_FFF0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
